// File: rtl/zynet_weight_loader.sv
// Streams zyNet parameters into the layer RAMs as a flat {layer, ram, addr} write bus.
// Optional trailing checksum word: define ZYNET_LOADER_CHECKSUM_EN.
module zynet_weight_loader #(
  parameter int MEM_WORD_SIZE     = 21,
  parameter int LAYER_SELECT_BITS = 2,
  parameter int RAM_SELECT_BITS   = 8,
  parameter int RAM_ADDRESS_BITS  = 9,
  parameter int L0_RAMS  = 256,
  parameter int L0_DEPTH = 33,
  parameter int L1_RAMS  = 256,
  parameter int L1_DEPTH = 257,
  parameter int L2_RAMS  = 4,
  parameter int L2_DEPTH = 256,
  parameter int L3_RAMS  = 10,
  parameter int L3_DEPTH = 257
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     load_start_i,
  input  logic [MEM_WORD_SIZE-1:0] data_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  output logic                     w_en_o,
  output logic [MEM_WORD_SIZE-1:0] w_data_o,
  output logic [LAYER_SELECT_BITS+RAM_SELECT_BITS+RAM_ADDRESS_BITS-1:0] w_addr_o,
  output logic                     busy_o,
  output logic                     done_o,
  output logic                     err_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_CHECK = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]                   state;
  logic [LAYER_SELECT_BITS-1:0] layer;
  logic [RAM_SELECT_BITS-1:0]   ram;
  logic [RAM_ADDRESS_BITS-1:0]  addr;
  logic                         accept;
  logic                         ram_end;
  logic                         layer_end;
  logic                         last_word;

  function automatic logic [RAM_ADDRESS_BITS-1:0] last_addr(input logic [LAYER_SELECT_BITS-1:0] l);
    case (int'(l))
      0:       return RAM_ADDRESS_BITS'(L0_DEPTH - 1);
      1:       return RAM_ADDRESS_BITS'(L1_DEPTH - 1);
      2:       return RAM_ADDRESS_BITS'(L2_DEPTH - 1);
      default: return RAM_ADDRESS_BITS'(L3_DEPTH - 1);
    endcase
  endfunction

  function automatic logic [RAM_SELECT_BITS-1:0] last_ram(input logic [LAYER_SELECT_BITS-1:0] l);
    case (int'(l))
      0:       return RAM_SELECT_BITS'(L0_RAMS - 1);
      1:       return RAM_SELECT_BITS'(L1_RAMS - 1);
      2:       return RAM_SELECT_BITS'(L2_RAMS - 1);
      default: return RAM_SELECT_BITS'(L3_RAMS - 1);
    endcase
  endfunction

  assign ready_o   = (state == S_LOAD) || (state == S_CHECK);
  assign busy_o    = ready_o;
  assign done_o    = (state == S_DONE);
  assign accept    = valid_i && ready_o;
  assign ram_end   = (addr == last_addr(layer));
  assign layer_end = ram_end && (ram == last_ram(layer));
  assign last_word = layer_end && (layer == LAYER_SELECT_BITS'(3));

`ifdef ZYNET_LOADER_CHECKSUM_EN
  logic [MEM_WORD_SIZE-1:0] sum;
  logic                     err_q;
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state    <= S_IDLE;
      layer    <= '0;
      ram      <= '0;
      addr     <= '0;
      w_en_o   <= 1'b0;
      w_data_o <= '0;
      w_addr_o <= '0;
`ifdef ZYNET_LOADER_CHECKSUM_EN
      sum      <= '0;
      err_q    <= 1'b0;
`endif
    end else begin
      w_en_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (load_start_i) begin
            state <= S_LOAD;
            layer <= '0;
            ram   <= '0;
            addr  <= '0;
`ifdef ZYNET_LOADER_CHECKSUM_EN
            sum   <= '0;
            err_q <= 1'b0;
`endif
          end
        end
        // Accepted word is registered onto the write bus with its acceptance-time address.
        S_LOAD: begin
          if (accept) begin
            w_en_o   <= 1'b1;
            w_data_o <= data_i;
            w_addr_o <= {layer, ram, addr};
`ifdef ZYNET_LOADER_CHECKSUM_EN
            sum      <= sum + data_i;
`endif
            if (!ram_end) begin
              addr <= addr + RAM_ADDRESS_BITS'(1);
            end else begin
              addr <= '0;
              if (!layer_end) begin
                ram <= ram + RAM_SELECT_BITS'(1);
              end else begin
                ram   <= '0;
                layer <= layer + LAYER_SELECT_BITS'(1);
              end
            end
            if (last_word) begin
`ifdef ZYNET_LOADER_CHECKSUM_EN
              state <= S_CHECK;
`else
              state <= S_DONE;
`endif
            end
          end
        end
`ifdef ZYNET_LOADER_CHECKSUM_EN
        S_CHECK: begin
          if (accept) begin
            err_q <= (data_i != sum);
            state <= S_DONE;
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_zynet_weight_loader.sv
// Directed bench for zynet_weight_loader on a reduced 26-word parameter map.
module tb_zynet_weight_loader;
  localparam int MW = 21;
  localparam int AW = 19;
  localparam int NW = 26;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          load_start_i = 1'b0;
  logic [MW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o, w_en_o, busy_o, done_o, err_o;
  logic [MW-1:0] w_data_o;
  logic [AW-1:0] w_addr_o;

  always #5 clk = ~clk;

  zynet_weight_loader #(
    .L0_RAMS(2), .L0_DEPTH(3), .L1_RAMS(2), .L1_DEPTH(3),
    .L2_RAMS(4), .L2_DEPTH(2), .L3_RAMS(2), .L3_DEPTH(3)
  ) dut (
    .clk_i(clk), .reset_i(reset_i), .load_start_i(load_start_i),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .w_en_o(w_en_o), .w_data_o(w_data_o), .w_addr_o(w_addr_o),
    .busy_o(busy_o), .done_o(done_o), .err_o(err_o)
  );

  int            n_vec = 0;
  int            n_err = 0;
  int            widx = 0;
  int            done_cnt = 0;
  int            cur_load = 0;
  logic [AW-1:0] tab [NW];
  logic [AW-1:0] got [NW];

  function automatic logic [MW-1:0] word_val(input int ld, input int i);
    return MW'(ld * 7919 + i * 131 + 5);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Fill-order model: every layer, every RAM, ascending address.
  initial begin
    int rams [4] = '{2, 2, 4, 2};
    int dep  [4] = '{3, 3, 2, 3};
    int n = 0;
    for (int l = 0; l < 4; l++)
      for (int r = 0; r < rams[l]; r++)
        for (int a = 0; a < dep[l]; a++) begin
          tab[n] = {2'(l), 8'(r), 9'(a)};
          n++;
        end
  end

  always @(negedge clk) begin
    if (w_en_o) begin
      if (widx >= NW) check("write_index", widx, NW - 1);
      else begin
        check("w_addr", 32'(w_addr_o), 32'(tab[widx]));
        check("w_data", 32'(w_data_o), 32'(word_val(cur_load, widx)));
        got[widx] = w_addr_o;
      end
      widx++;
    end
    if (done_o) begin
      done_cnt++;
      check("done_after_all_writes", widx, NW);
      widx = 0;
    end
    if (reset_i) widx = 0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(ready_o), 0);
    check({tag, "_w_en"}, 32'(w_en_o), 0);
    check({tag, "_busy"}, 32'(busy_o), 0);
    check({tag, "_done"}, 32'(done_o), 0);
    check({tag, "_err"}, 32'(err_o), 0);
    check({tag, "_w_data"}, 32'(w_data_o), 0);
    check({tag, "_w_addr"}, 32'(w_addr_o), 0);
  endtask

  task automatic send_word(input logic [MW-1:0] d, input int gap, input bit pulse);
    valid_i = 1'b0;
    repeat (gap) tick();
    data_i  = d;
    valid_i = 1'b1;
    if (pulse) load_start_i = 1'b1;
    for (int t = 0; t < 100; t++) begin
      if (ready_o) begin
        tick();
        valid_i      = 1'b0;
        load_start_i = 1'b0;
        return;
      end
      tick();
    end
    check("accept_timeout", 32'(ready_o), 1);
    valid_i      = 1'b0;
    load_start_i = 1'b0;
  endtask

  task automatic run_load(input int ld, input bit gaps, input int pulse_at, input int abort_at,
                          input bit bad_sum);
    int            d0;
    logic [MW-1:0] sum;
    d0  = done_cnt;
    sum = '0;
    cur_load = ld;
    load_start_i = 1'b1;
    tick();
    load_start_i = 1'b0;
    check("busy_after_start", 32'(busy_o), 1);
    for (int i = 0; i < NW; i++) begin
      if (i == abort_at) begin
        reset_i = 1'b1;
        tick();
        check_all_zero("abort");
        reset_i = 1'b0;
        return;
      end
      sum = sum + word_val(ld, i);
      send_word(word_val(ld, i), gaps ? int'($urandom_range(3, 0)) : 0, i == pulse_at);
    end
`ifdef ZYNET_LOADER_CHECKSUM_EN
    check("ready_in_check", 32'(ready_o), 1);
    send_word(bad_sum ? ~sum : sum, 0, 1'b0);
    repeat (3) tick();
    check("err_o", 32'(err_o), 32'(bad_sum));
`else
    check("ready_after_last_word", 32'(ready_o), 0);
    repeat (3) tick();
    check("err_o", 32'(err_o), 0);
`endif
    check("done_pulses", done_cnt - d0, 1);
    check("idle_after_done", 32'(busy_o), 0);
  endtask

  initial begin
    repeat (3) tick();
    reset_i = 1'b0;
    tick();
    check_all_zero("reset");

    data_i  = word_val(1, 0);
    valid_i = 1'b1;
    repeat (3) begin
      tick();
      check("early_valid_ready", 32'(ready_o), 0);
      check("early_valid_w_en", 32'(w_en_o), 0);
    end

    run_load(1, 1'b0, -1, -1, 1'b0);
    check("word1_addr", 32'(got[0]), 32'h00000);
    check("word6_addr", 32'(got[5]), 32'h00202);
    check("word7_addr", 32'(got[6]), 32'h20000);
    check("word26_addr", 32'(got[25]), 32'h60202);

    run_load(2, 1'b1, 5, -1, 1'b0);
    run_load(3, 1'b0, -1, 10, 1'b0);
    got[0] = '1;
    run_load(4, 1'b0, -1, -1, 1'b0);
    check("restart_addr", 32'(got[0]), 32'h00000);
`ifdef ZYNET_LOADER_CHECKSUM_EN
    run_load(5, 1'b1, -1, -1, 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
